// File: rtl/instr_fetch_if.sv
// Bus between the fetch stage and its surroundings: decode-side control,
// synchronous instruction memory, and the IF/ID outputs presented to decode.
interface instr_fetch_if #(
   parameter int AW = 16
);
   logic          stall;
   logic          br_taken;
   logic [AW-1:0] br_target;
   logic          imem_en;
   logic [AW-2:0] imem_addr;
   logic [15:0]   imem_rdata;
   logic [15:0]   instr_id;
   logic [AW-1:0] pc_id;
   logic          valid_id;

   modport master (
      input  stall, br_taken, br_target, imem_rdata,
      output imem_en, imem_addr, instr_id, pc_id, valid_id
   );

   modport slave (
      output stall, br_taken, br_target, imem_rdata,
      input  imem_en, imem_addr, instr_id, pc_id, valid_id
   );
endinterface

// File: rtl/instr_fetch.sv
// Thumb fetch stage plus IF/ID register: PC, one in-flight memory read, a one-entry
// skid buffer that catches read data returning during a stall, and branch squashing.
module instr_fetch #(
   parameter int          AW        = 16,
   parameter logic [AW-1:0] RESET_PC  = '0,
   parameter logic [15:0] NOP_INSTR = 16'hBF00
) (
   input  logic          clk,
   input  logic          reset_n,
   instr_fetch_if.master fetchBus
);

   logic [AW-1:0] pc_q, pc_d;
   logic          fqValid_q, fqValid_d;
   logic [AW-1:0] fqPc_q, fqPc_d;
   logic          skidValid_q, skidValid_d;
   logic [15:0]   skidData_q, skidData_d;
   logic [AW-1:0] skidPc_q, skidPc_d;
   logic [15:0]   instrId_q, instrId_d;
   logic [AW-1:0] pcId_q, pcId_d;
   logic          validId_q, validId_d;

   logic          issue;
   logic [AW-1:0] brTargetAligned;

   assign issue           = reset_n & ~fetchBus.stall & ~fetchBus.br_taken;
   // Bit 0 of a BX target is the Thumb state bit, never part of the address.
   assign brTargetAligned = fetchBus.br_target & ~{{(AW-1){1'b0}}, 1'b1};

   assign fetchBus.imem_en   = issue;
   assign fetchBus.imem_addr = pc_q[AW-1:1];
   assign fetchBus.instr_id  = instrId_q;
   assign fetchBus.pc_id     = pcId_q;
   assign fetchBus.valid_id  = validId_q;

   always_comb begin
      pc_d        = pc_q;
      fqValid_d   = 1'b0;
      fqPc_d      = fqPc_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;
      skidPc_d    = skidPc_q;
      instrId_d   = instrId_q;
      pcId_d      = pcId_q;
      validId_d   = validId_q;

      if (fetchBus.br_taken) begin
         pc_d        = brTargetAligned;
         instrId_d   = NOP_INSTR;
         validId_d   = 1'b0;
         skidValid_d = 1'b0;
      end else if (fetchBus.stall) begin
         // Data for the read already in flight must be parked, the memory won't hold it.
         if (fqValid_q) begin
            skidData_d  = fetchBus.imem_rdata;
            skidPc_d    = fqPc_q;
            skidValid_d = 1'b1;
         end
      end else begin
         pc_d      = pc_q + AW'(2);
         fqValid_d = 1'b1;
         fqPc_d    = pc_q;
         if (skidValid_q) begin
            instrId_d   = skidData_q;
            pcId_d      = skidPc_q;
            validId_d   = 1'b1;
            skidValid_d = 1'b0;
         end else if (fqValid_q) begin
            instrId_d = fetchBus.imem_rdata;
            pcId_d    = fqPc_q;
            validId_d = 1'b1;
         end else begin
            instrId_d = NOP_INSTR;
            validId_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q        <= RESET_PC;
         fqValid_q   <= 1'b0;
         fqPc_q      <= '0;
         skidValid_q <= 1'b0;
         skidData_q  <= NOP_INSTR;
         skidPc_q    <= '0;
         instrId_q   <= NOP_INSTR;
         pcId_q      <= '0;
         validId_q   <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         fqValid_q   <= fqValid_d;
         fqPc_q      <= fqPc_d;
         skidValid_q <= skidValid_d;
         skidData_q  <= skidData_d;
         skidPc_q    <= skidPc_d;
         instrId_q   <= instrId_d;
         pcId_q      <= pcId_d;
         validId_q   <= validId_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 16-bit instance walked through free-run, stall,
// branch, branch-during-stall and mid-stream reset, plus a 4-bit instance for PC wrap.
module tb_instr_fetch;

   logic clk;
   logic reset_n;
   logic resetSmall_n;
   int   checkCount;
   int   errorCount;

   instr_fetch_if #(.AW(16)) fBus ();
   instr_fetch_if #(.AW(4))  sBus ();

   instr_fetch #(.AW(16), .RESET_PC(16'h0000), .NOP_INSTR(16'hBF00)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .fetchBus (fBus.master)
   );

   instr_fetch #(.AW(4), .RESET_PC(4'hE), .NOP_INSTR(16'hBF00)) dutSmall (
      .clk      (clk),
      .reset_n  (resetSmall_n),
      .fetchBus (sBus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous instruction memories holding mem[i] = 16'h1000 + i.
   always @(posedge clk) begin
      if (fBus.imem_en) fBus.imem_rdata <= 16'h1000 + 16'(fBus.imem_addr);
   end

   always @(posedge clk) begin
      if (sBus.imem_en) sBus.imem_rdata <= 16'h1000 + 16'(sBus.imem_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkId(input string tag, input logic [15:0] expInstr,
                          input logic [15:0] expPc);
      checkOutput({tag, " instr"}, 32'(fBus.instr_id), 32'(expInstr));
      checkOutput({tag, " pc"},    32'(fBus.pc_id),    32'(expPc));
      checkOutput({tag, " valid"}, 32'(fBus.valid_id), 32'd1);
   endtask

   task automatic checkBubble(input string tag);
      checkOutput({tag, " instr"}, 32'(fBus.instr_id), 32'h0000BF00);
      checkOutput({tag, " valid"}, 32'(fBus.valid_id), 32'd0);
   endtask

   task automatic applyStimulus();
      // Reset
      reset_n           = 1'b0;
      resetSmall_n      = 1'b0;
      fBus.stall        = 1'b0;
      fBus.br_taken     = 1'b0;
      fBus.br_target    = '0;
      sBus.stall        = 1'b0;
      sBus.br_taken     = 1'b0;
      sBus.br_target    = '0;
      stepCycle();
      checkBubble("reset");
      checkOutput("reset addr", 32'(fBus.imem_addr), 32'h0);
      checkOutput("reset en", 32'(fBus.imem_en), 32'd0);
      reset_n = 1'b1;

      // Free run
      stepCycle();
      checkBubble("run first");
      checkOutput("run en", 32'(fBus.imem_en), 32'd1);
      for (int k = 2; k <= 4; k++) begin
         stepCycle();
         checkId("run", 16'(16'h1000 + k - 2), 16'(2 * (k - 2)));
         checkOutput("run addr", 32'(fBus.imem_addr), 32'(k));
      end

      // Stall three cycles while pc 6 is in flight
      fBus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         checkId("stall hold", 16'h1002, 16'h0004);
         checkOutput("stall en", 32'(fBus.imem_en), 32'd0);
         checkOutput("stall addr", 32'(fBus.imem_addr), 32'h4);
      end
      fBus.stall = 1'b0;
      stepCycle();
      checkId("stall skid", 16'h1003, 16'h0006);
      stepCycle();
      checkId("stall after", 16'h1004, 16'h0008);

      // Branch to 0x41 (bit 0 dropped)
      fBus.br_taken  = 1'b1;
      fBus.br_target = 16'h0041;
      stepCycle();
      fBus.br_taken = 1'b0;
      checkBubble("br bubble1");
      checkOutput("br addr", 32'(fBus.imem_addr), 32'h20);
      stepCycle();
      checkBubble("br bubble2");
      stepCycle();
      checkId("br target", 16'h1020, 16'h0040);

      // Branch while stalled with the skid buffer full
      fBus.stall = 1'b1;
      stepCycle();
      checkId("brst hold", 16'h1020, 16'h0040);
      fBus.br_taken  = 1'b1;
      fBus.br_target = 16'h0080;
      #1;
      checkOutput("brst en", 32'(fBus.imem_en), 32'd0);
      stepCycle();
      fBus.br_taken = 1'b0;
      fBus.stall    = 1'b0;
      checkBubble("brst bubble1");
      checkOutput("brst addr", 32'(fBus.imem_addr), 32'h40);
      stepCycle();
      checkBubble("brst bubble2");
      stepCycle();
      checkId("brst target", 16'h1040, 16'h0080);

      // Reset mid-stream with the skid buffer full
      fBus.stall = 1'b1;
      stepCycle();
      checkId("rst hold", 16'h1040, 16'h0080);
      reset_n = 1'b0;
      stepCycle();
      reset_n    = 1'b1;
      fBus.stall = 1'b0;
      checkBubble("rst bubble1");
      checkOutput("rst addr", 32'(fBus.imem_addr), 32'h0);
      stepCycle();
      checkBubble("rst bubble2");
      stepCycle();
      checkId("rst restart", 16'h1000, 16'h0000);

      // 4-bit PC wrap from 0xE
      checkOutput("wrap reset addr", 32'(sBus.imem_addr), 32'h7);
      resetSmall_n = 1'b1;
      stepCycle();
      checkOutput("wrap bubble valid", 32'(sBus.valid_id), 32'd0);
      checkOutput("wrap addr", 32'(sBus.imem_addr), 32'h0);
      stepCycle();
      checkOutput("wrap instr0", 32'(sBus.instr_id), 32'h1007);
      checkOutput("wrap pc0", 32'(sBus.pc_id), 32'hE);
      stepCycle();
      checkOutput("wrap instr1", 32'(sBus.instr_id), 32'h1000);
      checkOutput("wrap pc1", 32'(sBus.pc_id), 32'h0);
      stepCycle();
      checkOutput("wrap instr2", 32'(sBus.instr_id), 32'h1001);
      checkOutput("wrap pc2", 32'(sBus.pc_id), 32'h2);
      checkOutput("wrap valid", 32'(sBus.valid_id), 32'd1);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
